// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes.
// Independent write and read FSMs; all registers are also visible on REGS_OUT.
module axi4lite_regfile_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    // Write path state
    w_state_t              w_state_reg, w_state_next;
    logic                  aw_held_reg, w_held_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]     w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  commit, resp_done;
    logic [IDX_W-1:0]      aw_idx;
    logic                  aw_in_range;

    // Read path state
    r_state_t              r_state_reg, r_state_next;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;
    logic                  ar_fire;

    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, aw_addr_reg[1:0], ARADDR[1:0]};

    // Anything with an address bit set above the register window is out of range
    assign aw_idx      = aw_addr_reg[IDX_W+1:2];
    assign aw_in_range = (aw_addr_reg >> (IDX_W + 2)) == '0;
    assign ar_idx      = ARADDR[IDX_W+1:2];
    assign ar_in_range = (ARADDR >> (IDX_W + 2)) == '0;

    assign AWREADY = !ARESET && (w_state_reg == W_IDLE) && !aw_held_reg;
    assign WREADY  = !ARESET && (w_state_reg == W_IDLE) && !w_held_reg;
    assign ARREADY = !ARESET && (r_state_reg == R_IDLE);
    assign ar_fire = ARVALID && ARREADY;

    assign BVALID = bvalid_reg;
    assign BRESP  = bresp_reg;
    assign RVALID = rvalid_reg;
    assign RDATA  = rdata_reg;
    assign RRESP  = rresp_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign REGS_OUT[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
        end
    endgenerate

    // Write FSM
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        commit       = 1'b0;
        resp_done    = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_held_reg && w_held_reg) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    resp_done    = 1'b1;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_addr_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (AWVALID && AWREADY) begin
                aw_held_reg <= 1'b1;
                aw_addr_reg <= AWADDR;
            end
            if (WVALID && WREADY) begin
                w_held_reg <= 1'b1;
                w_data_reg <= WDATA;
                w_strb_reg <= WSTRB;
            end
            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (resp_done) begin
                bvalid_reg  <= 1'b0;
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
        end
    end

    // Register array: byte-lane masked update on commit
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit && aw_in_range) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (w_strb_reg[k]) begin
                    regs_reg[aw_idx][k*8 +: 8] <= w_data_reg[k*8 +: 8];
                end
            end
        end
    end

    // Read FSM
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ARVALID) r_state_next = R_DATA;
            R_DATA:  if (RREADY)  r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Capture samples the pre-commit register value when a write lands on the same edge
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_reg <= 1'b1;
            if (ar_in_range) begin
                rdata_reg <= regs_reg[ar_idx];
                rresp_reg <= RESP_OKAY;
            end else begin
                rdata_reg <= '0;
                rresp_reg <= RESP_SLVERR;
            end
        end else if (rvalid_reg && RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Self-checking bench for axi4lite_regfile_slave: vector table driven through
// AXI tasks, responses checked by a scoreboard monitor, plus corner sequences.
module tb_axi4lite_regfile_slave;

    logic         ACLK;
    logic         ARESET;
    logic [31:0]  AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [31:0]  ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [255:0] REGS_OUT;

    axi4lite_regfile_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REGS_OUT(REGS_OUT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        int          delay;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int b_seen = 0;
    int b_total = 0;
    int r_seen = 0;
    int r_total = 0;
    logic [1:0]  b_q [$];
    rexp_t       r_q [$];
    logic [31:0] model [8];
    vec_t        vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboard: a handshake visible before the edge completes on that edge
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [1:0] be;
                    be = b_q.pop_front();
                    check("bresp", {30'd0, BRESP}, {30'd0, be});
                    $display("B  resp=%0d exp=%0d", BRESP, be);
                end
                b_seen++;
            end
            if (RVALID && RREADY) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 32'd1, 32'd0);
                end else begin
                    rexp_t re;
                    re = r_q.pop_front();
                    check("rdata", RDATA, re.data);
                    check("rresp", {30'd0, RRESP}, {30'd0, re.resp});
                    $display("R  data=0x%08h resp=%0d exp=0x%08h/%0d", RDATA, RRESP, re.data, re.resp);
                end
                r_seen++;
            end
        end
    end

    task automatic check_regs(input string name);
        for (int i = 0; i < 8; i++) begin
            check(name, REGS_OUT[i*32 +: 32], model[i]);
        end
    endtask

    task automatic wait_b;
        for (int i = 0; i < 20 && b_seen < b_total; i++) tick;
        check("b_timeout", b_seen, b_total);
    endtask

    task automatic wait_r;
        for (int i = 0; i < 20 && r_seen < r_total; i++) tick;
        check("r_timeout", r_seen, r_total);
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int bdelay, input logic [1:0] exp_resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_fire, w_fire;
        int cyc = 0;
        b_q.push_back(exp_resp);
        b_total++;
        if (addr < 32'h20) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) model[addr[4:2]][k*8 +: 8] = data[k*8 +: 8];
        end
        BREADY = (bdelay == 0);
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 20) begin
            if (!w_done && cyc >= ((lead < 0) ? -lead : 0)) WVALID = 1'b1;
            if (!aw_done && cyc >= ((lead > 0) ? lead : 0)) AWVALID = 1'b1;
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            tick;
            cyc++;
            if (aw_fire) begin aw_done = 1; AWVALID = 1'b0; end
            if (w_fire)  begin w_done = 1;  WVALID = 1'b0;  end
        end
        check("w_handshake", {30'd0, aw_done, w_done}, 32'd3);
        check("bvalid_pre_commit", BVALID, 32'd0);
        tick;
        check("bvalid_commit", BVALID, 32'd1);
        check_regs("regs_out_commit");
        for (int d = 0; d < bdelay; d++) begin
            tick;
            check("bvalid_hold", BVALID, 32'd1);
            check("bresp_hold", {30'd0, BRESP}, {30'd0, exp_resp});
        end
        BREADY = 1'b1;
        wait_b;
        BREADY = 1'b0;
        check("bvalid_drop", BVALID, 32'd0);
        $display("WR addr=0x%08h data=0x%08h strb=0x%h lead=%0d", addr, data, strb, lead);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdelay,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit fire = 0;
        rexp_t re;
        re.data = exp_data;
        re.resp = exp_resp;
        r_q.push_back(re);
        r_total++;
        RREADY  = 1'b0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        for (int i = 0; i < 20 && !fire; i++) begin
            fire = ARVALID && ARREADY;
            tick;
        end
        ARVALID = 1'b0;
        check("ar_handshake", {31'd0, fire}, 32'd1);
        check("rvalid_latency", RVALID, 32'd1);
        check("arready_busy", ARREADY, 32'd0);
        for (int d = 0; d < rdelay; d++) begin
            tick;
            check("rvalid_hold", RVALID, 32'd1);
            check("rdata_hold", RDATA, exp_data);
            check("arready_hold", ARREADY, 32'd0);
        end
        RREADY = 1'b1;
        wait_r;
        RREADY = 1'b0;
        check("arready_idle", ARREADY, 32'd1);
        $display("RD addr=0x%08h exp=0x%08h/%0d", addr, exp_data, exp_resp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rd addr          data           strb lead dly exp_data       resp
        vecs[0]  = '{0, 32'h0000_0004, 32'hDEADBEEF, 4'hF,  0, 3, 32'h0,         2'b00};
        vecs[1]  = '{0, 32'h0000_0008, 32'hAABBCCDD, 4'hF,  0, 0, 32'h0,         2'b00};
        vecs[2]  = '{0, 32'h0000_0008, 32'h11223344, 4'h5,  2, 0, 32'h0,         2'b00};
        vecs[3]  = '{1, 32'h0000_0008, 32'h0,        4'h0,  0, 0, 32'hAA22CC44,  2'b00};
        vecs[4]  = '{0, 32'h0000_0040, 32'h55555555, 4'hF,  0, 1, 32'h0,         2'b10};
        vecs[5]  = '{1, 32'h0000_0040, 32'h0,        4'h0,  0, 0, 32'h0,         2'b10};
        vecs[6]  = '{1, 32'h0000_0004, 32'h0,        4'h0,  0, 2, 32'hDEADBEEF,  2'b00};
        vecs[7]  = '{0, 32'h0000_001C, 32'hCAFEF00D, 4'h0,  0, 0, 32'h0,         2'b00};
        vecs[8]  = '{1, 32'h0000_001C, 32'h0,        4'h0,  0, 0, 32'h0,         2'b00};
        vecs[9]  = '{0, 32'h0000_001F, 32'h01020304, 4'hC,  0, 0, 32'h0,         2'b00};
        vecs[10] = '{1, 32'h0000_001D, 32'h0,        4'h0,  0, 1, 32'h01020000,  2'b00};
        vecs[11] = '{0, 32'h0000_0020, 32'h00000001, 4'hF,  0, 0, 32'h0,         2'b10};
        vecs[12] = '{1, 32'h0000_0020, 32'h0,        4'h0,  0, 0, 32'h0,         2'b10};
        vecs[13] = '{0, 32'h0000_0000, 32'h13579BDF, 4'h3,  1, 0, 32'h0,         2'b00};
        vecs[14] = '{1, 32'h0000_0000, 32'h0,        4'h0,  0, 0, 32'h00009BDF,  2'b00};
        vecs[15] = '{1, 32'h1000_0004, 32'h0,        4'h0,  0, 0, 32'h0,         2'b10};
        vecs[16] = '{0, 32'h0000_0014, 32'h0BADCAFE, 4'hF, -2, 0, 32'h0,         2'b00};
        vecs[17] = '{1, 32'h0000_0014, 32'h0,        4'h0,  0, 0, 32'h0BADCAFE,  2'b00};

        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        ARESET = 1'b1;
        AWADDR = '0; AWPROT = 3'b000; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) tick;

        // Reset state
        check("awready_in_reset", AWREADY, 32'd0);
        check("wready_in_reset", WREADY, 32'd0);
        check("arready_in_reset", ARREADY, 32'd0);
        ARESET = 1'b0;
        #1;
        check("awready_after_reset", AWREADY, 32'd1);
        check("wready_after_reset", WREADY, 32'd1);
        check("arready_after_reset", ARREADY, 32'd1);
        check("bvalid_reset", BVALID, 32'd0);
        check("rvalid_reset", RVALID, 32'd0);
        check("rdata_reset", RDATA, 32'd0);
        check("bresp_reset", {30'd0, BRESP}, 32'd0);
        check_regs("regs_reset");
        tick;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_read)
                axi_read(vecs[i].addr, vecs[i].delay, vecs[i].exp_data, vecs[i].exp_resp);
            else
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead,
                          vecs[i].delay, vecs[i].exp_resp);
        end

        // Read capture on the same edge as a write commit to the same register
        AWADDR = 32'h0C; WDATA = 32'h12345678; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        b_q.push_back(2'b00); b_total++;
        r_q.push_back('{data: 32'h0, resp: 2'b00}); r_total++;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h0C; ARVALID = 1'b1;
        tick;
        ARVALID = 1'b0;
        model[3] = 32'h12345678;
        check("race_bvalid", BVALID, 32'd1);
        check("race_rvalid", RVALID, 32'd1);
        check("race_rdata_old", RDATA, 32'h0);
        check("race_reg3_new", REGS_OUT[3*32 +: 32], 32'h12345678);
        BREADY = 1'b1; RREADY = 1'b1;
        wait_b;
        wait_r;
        BREADY = 1'b0; RREADY = 1'b0;
        $display("RACE read/write reg3 done");

        // Reset with AW accepted and W still outstanding
        AWADDR = 32'h10; AWVALID = 1'b1;
        tick;
        AWVALID = 1'b0;
        ARESET = 1'b1;
        #1;
        check("awready_mid_reset", AWREADY, 32'd0);
        check("wready_mid_reset", WREADY, 32'd0);
        check("arready_mid_reset", ARREADY, 32'd0);
        tick;
        tick;
        ARESET = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        for (int c = 0; c < 3; c++) begin
            tick;
            check("bvalid_after_abort", BVALID, 32'd0);
        end
        check_regs("regs_after_abort");
        $display("ABORT write cleared by reset");
        axi_write(32'h18, 32'h600DF00D, 4'hF, 2, 0, 2'b00);
        axi_read(32'h18, 0, 32'h600DF00D, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
